// File: rtl/d7s_scan_ctrl.sv
// Scan scheduler for a 3-digit multiplexed 7-segment display: frame-synchronous
// value commit, BCD decode, dwell/blank timing, PWM dimming, leading-zero blanking.
module d7s_scan_ctrl #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [BLANK_W-1:0] blank_cycles,
  input  logic [3:0]         brightness,
  input  logic               lzs_en,
  input  logic               upd_valid,
  input  logic [11:0]        upd_bcd,
  output logic               upd_ready,
  output logic [2:0]         transistor,
  output logic [6:0]         d7sp,
  output logic               frame_tick
);

  localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t           r_state, w_state_nxt, w_gap_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_gap_cnt, w_dwell_m1, w_blank_m1;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [3:0]       r_pwm;
  logic [11:0]      r_disp, r_pend;
  logic             r_upd_ready;
  logic             w_boundary, w_commit, w_accept;
  logic [3:0]       w_digit;
  logic             w_blanked;
  logic [2:0]       r_tr;
  logic [6:0]       r_seg;
  logic             r_tick;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111110;
    endcase
  endfunction

  // Phase lengths minus one; a zero dwell still gives one ON cycle
  assign w_dwell_m1 = (dwell_cycles == '0) ? '0 : CNT_W'(dwell_cycles - DWELL_W'(1));
  assign w_blank_m1 = CNT_W'(blank_cycles - BLANK_W'(1));
  assign w_gap_state = (blank_cycles == '0) ? S_ON : S_BLANK;
  assign w_gap_cnt   = (blank_cycles == '0) ? w_dwell_m1 : w_blank_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (en) begin
          w_state_nxt = w_gap_state;
          w_cnt_nxt   = w_gap_cnt;
        end
      end
      S_BLANK: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = w_dwell_m1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ON: begin
        if (r_cnt == '0) begin
          w_boundary  = (r_idx == 2'd2);
          w_idx_nxt   = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
          w_state_nxt = w_gap_state;
          w_cnt_nxt   = w_gap_cnt;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_boundary  = 1'b0;
    end
  end

  assign w_commit = w_boundary && !r_upd_ready;
  assign w_accept = upd_valid && r_upd_ready;

  // Pending buffer and display register; a commit never coincides with an accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_upd_ready <= 1'b1;
      r_pwm       <= '0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
      if (w_commit) r_disp <= r_pend;
      if (w_accept) r_pend <= upd_bcd;
      if (w_accept)      r_upd_ready <= 1'b0;
      else if (w_commit) r_upd_ready <= 1'b1;
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = r_disp[3:0];
      2'd1:    w_digit = r_disp[7:4];
      default: w_digit = r_disp[11:8];
    endcase
    w_blanked = lzs_en && (((r_idx == 2'd2) && (r_disp[11:8] == 4'd0)) ||
                           ((r_idx == 2'd1) && (r_disp[11:4] == 8'd0)));
  end

  // Gating with en darkens the display on the cycle right after en drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tr   <= 3'b111;
      r_seg  <= 7'b1111111;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_boundary;
      if (!en || (r_state != S_ON) || w_blanked) begin
        r_tr  <= 3'b111;
        r_seg <= 7'b1111111;
      end else begin
        r_seg <= seg_decode(w_digit);
        r_tr  <= (r_pwm <= brightness) ? ~(3'(1) << r_idx) : 3'b111;
      end
    end
  end

  assign upd_ready  = r_upd_ready;
  assign transistor = r_tr;
  assign d7sp       = r_seg;
  assign frame_tick = r_tick;

endmodule
